// File: rtl/modhalf_pkg.sv
// Shared constants, tag type and helpers for the modular-halving arbiter.
// q = 3329, and 2^-1 mod q = 1665.
package modhalf_pkg;

   localparam int Q         = 3329;
   localparam int HALF_Q    = 1665;
   localparam int DEF_WIDTH = 12;
   localparam int MAX_ID_W  = 3;

   // One entry of the tag pipeline; the id is wide enough for up to 8 requesters.
   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

   function automatic int id_w(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/modhalfq.sv
// Modular halving unit: r = a * 2^-1 mod q, with LAT output pipeline stages.
// Operands >= q still follow the same odd/even rule.
module modhalfq
   import modhalf_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LAT   = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_a,
   output logic [WIDTH-1:0] o_r
);

   logic [WIDTH-1:0] w_shr;
   logic [WIDTH-1:0] w_half;
   logic [WIDTH-1:0] r_pipe [0:LAT-1];

   // An odd a is a+q made even, so (a+q)/2 = (a>>1) + (q+1)/2.
   assign w_shr  = {1'b0, i_a[WIDTH-1:1]};
   assign w_half = i_a[0] ? (w_shr + WIDTH'(HALF_Q)) : w_shr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
      end else begin
         r_pipe[0] <= w_half;
         for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign o_r = r_pipe[LAT-1];

endmodule

// File: rtl/modhalfq_arb_rr_arb.sv
// Round-robin grant: search starts one past the pointer and wraps.
// Produces a one-hot grant and its encoded index.
module rr_arb #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx
);

   always_comb begin
      int   j;
      logic found;
      o_grant = '0;
      o_idx   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!found && i_req[j]) begin
            found      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/modhalfq_arb.sv
// Round-robin front end sharing one modhalfq between NREQ requesters.
// Accepts one operand per cycle, returns the halved result tagged with its owner.
module modhalfq_arb
   import modhalf_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int LAT   = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [NREQ*WIDTH-1:0]   i_req_data,
   output logic [NREQ-1:0]         o_req_ready,
   output logic                    o_rsp_valid,
   output logic [id_w(NREQ)-1:0]   o_rsp_id,
   output logic [WIDTH-1:0]        o_rsp_data,
   output logic                    o_busy,
   output logic                    o_err
);

   localparam int IW = id_w(NREQ);

   logic [IW-1:0]    r_ptr;
   logic [WIDTH-1:0] r_a;
   logic             r_err;
   tag_t             r_tag [0:LAT];
   logic             r_rsp_valid;
   logic [IW-1:0]    r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;

   logic [NREQ-1:0]  w_grant;
   logic [NREQ-1:0]  w_ready;
   logic [IW-1:0]    w_gidx;
   logic             w_xfer;
   logic [WIDTH-1:0] w_op;
   logic [WIDTH-1:0] w_half;
   tag_t             w_tag_in;
   logic [LAT:0]     w_tag_v;
   logic             w_unused;

   rr_arb #(.N(NREQ), .IW(IW)) u_rr_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx)
   );

   // No grant may leave the block while reset is held.
   assign w_ready = i_rst ? '0 : w_grant;
   assign w_xfer  = |w_ready;

   always_comb begin
      w_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_ready[i]) w_op = i_req_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      w_tag_in       = '0;
      w_tag_in.valid = w_xfer;
      w_tag_in.id    = MAX_ID_W'(w_gidx);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= IW'(NREQ-1);
         r_a   <= '0;
         r_err <= 1'b0;
      end else if (w_xfer) begin
         r_ptr <= w_gidx;
         r_a   <= w_op;
         if (w_op >= WIDTH'(Q)) r_err <= 1'b1;
      end
   end

   modhalfq #(.WIDTH(WIDTH), .LAT(LAT)) u_modhalfq (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_a   (r_a),
      .o_r   (w_half)
   );

   // Tag stage k lines up with the operand k cycles after it entered r_a.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
      end else begin
         r_tag[0] <= w_tag_in;
         for (int k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
      end
   end

   for (genvar gi = 0; gi <= LAT; gi++) begin : g_tag_v
      assign w_tag_v[gi] = r_tag[gi].valid;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= r_tag[LAT].valid;
         if (r_tag[LAT].valid) begin
            r_rsp_id   <= r_tag[LAT].id[IW-1:0];
            r_rsp_data <= w_half;
         end
      end
   end

   assign w_unused    = ^r_tag[LAT].id;
   assign o_req_ready = w_ready;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_data  = r_rsp_data;
   assign o_busy      = |w_tag_v;
   assign o_err       = r_err;

endmodule

// File: tb/tb_modhalfq_arb.sv
// Directed and random checks for modhalfq_arb (NREQ=4, WIDTH=12, LAT=1).
module tb_modhalfq_arb;

   localparam int NREQ = 4;
   localparam int W    = 12;
   localparam int NRND = 10000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] req_valid = '0;
   logic [NREQ*W-1:0] req_data = '0;
   logic [NREQ-1:0] req_ready;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [W-1:0]    rsp_data;
   logic            busy;
   logic            err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit log_en   = 1'b0;
   int rq_id[$];
   int rq_data[$];
   int rq_cyc[$];
   int g_log[$];

   modhalfq_arb #(.NREQ(NREQ), .WIDTH(W), .LAT(1)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_id    (rsp_id),
      .o_rsp_data  (rsp_data),
      .o_busy      (busy),
      .o_err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Records responses and grants away from the active edge.
   always @(negedge clk) begin
      if (rsp_valid) begin
         rq_id.push_back(int'(rsp_id));
         rq_data.push_back(int'(rsp_data));
         rq_cyc.push_back(cyc);
         if (log_en) $display("rsp id=%0d data=%0d cyc=%0d", rsp_id, rsp_data, cyc);
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_log.push_back(i);
   end

   function automatic int half_ref(input int a);
      return (a % 2 == 1) ? (a / 2) + 1665 : a / 2;
   endfunction

   task automatic set_data(input int i, input int a);
      req_data[i*W +: W] = W'(a);
   endtask

   task automatic clear_logs();
      rq_id.delete(); rq_data.delete(); rq_cyc.delete(); g_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_data = '0;
      repeat (3) @(posedge clk);
      #1 req_valid = 4'hF;
      #1;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_no_grant: got %b expected 0000", req_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
      n_checks++; if (rsp_id !== 2'd0 || rsp_data !== 12'd0) $display("FAIL reset_rsp: got id %0d data %0d expected 0 0", rsp_id, rsp_data); else n_pass++;
      n_checks++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL reset_busy_err: got %b%b expected 00", busy, err); else n_pass++;
      @(negedge clk) rst = 1'b0;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", req_ready); else n_pass++;
      req_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      log_en = 1'b1;
      req_valid = 4'b0001; set_data(0, 4);
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready); else n_pass++;
      @(posedge clk); #1 req_valid = '0;
      n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL single_c1: got busy %b valid %b expected 1 0", busy, rsp_valid); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL single_c2: got busy %b valid %b expected 1 0", busy, rsp_valid); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 12'd2) $display("FAIL single_rsp: got v%b id %0d data %0d expected v1 id 0 data 2", rsp_valid, rsp_id, rsp_data); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy %b expected 0", busy); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_one_cycle: got %b expected 0", rsp_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int c_acc;
      clear_logs();
      req_valid = 4'b0100; set_data(2, 3);
      @(posedge clk); #1 c_acc = cyc; set_data(2, 3328);
      @(posedge clk); #1 req_valid = '0;
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (rq_id.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", rq_id.size());
      else begin
         n_pass++;
         n_checks++; if (rq_id[0] !== 2 || rq_id[1] !== 2) $display("FAIL b2b_id: got %0d %0d expected 2 2", rq_id[0], rq_id[1]); else n_pass++;
         n_checks++; if (rq_data[0] !== 1666 || rq_data[1] !== 1664) $display("FAIL b2b_data: got %0d %0d expected 1666 1664", rq_data[0], rq_data[1]); else n_pass++;
         n_checks++; if (rq_cyc[0] !== c_acc + 2) $display("FAIL b2b_latency: got cyc %0d expected %0d", rq_cyc[0], c_acc + 2); else n_pass++;
         n_checks++; if (rq_cyc[1] !== rq_cyc[0] + 1) $display("FAIL b2b_consecutive: got cyc %0d expected %0d", rq_cyc[1], rq_cyc[0] + 1); else n_pass++;
      end
   endtask

   task automatic test_err();
      n_checks++; if (err !== 1'b0) $display("FAIL err_initial: got %b expected 0", err); else n_pass++;
      req_valid = 4'b0010; set_data(1, 3329);
      @(posedge clk); #1 req_valid = '0;
      n_checks++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else n_pass++;
      repeat (2) @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 12'd3329) $display("FAIL err_rsp: got v%b id %0d data %0d expected v1 id 1 data 3329", rsp_valid, rsp_id, rsp_data); else n_pass++;
      req_valid = 4'b0010; set_data(1, 0);
      @(posedge clk); #1 req_valid = '0;
      repeat (2) @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 12'd0) $display("FAIL err_zero_rsp: got v%b id %0d data %0d expected v1 id 1 data 0", rsp_valid, rsp_id, rsp_data); else n_pass++;
      n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err); else n_pass++;
   endtask

   task automatic test_reset_mid();
      req_valid = 4'b1000; set_data(3, 5);
      @(posedge clk); #1 set_data(3, 6);
      @(posedge clk); #1 req_valid = '0;
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 12'd1667) $display("FAIL mid_first_rsp: got v%b id %0d data %0d expected v1 id 3 data 1667", rsp_valid, rsp_id, rsp_data); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else n_pass++;
      #1 rst = 1'b1;
      #1;
      n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL mid_async_clear: got v%b busy %b err %b expected 000", rsp_valid, busy, err); else n_pass++;
      req_valid = 4'hF;
      #1;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL mid_no_grant: got %b expected 0000", req_ready); else n_pass++;
      clear_logs();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b expected 0001", req_ready); else n_pass++;
      req_valid = '0;
      repeat (5) @(posedge clk); #1;
      n_checks++; if (rq_id.size() !== 0) $display("FAIL mid_stale_rsp: got %0d responses expected 0", rq_id.size()); else n_pass++;
   endtask

   task automatic test_all_valid();
      int vals [4];
      int exp_h [4];
      vals  = '{100, 107, 114, 121};
      exp_h = '{50, 1718, 57, 1725};
      clear_logs();
      for (int i = 0; i < NREQ; i++) set_data(i, vals[i]);
      req_valid = 4'hF;
      repeat (12) @(posedge clk);
      #1 req_valid = '0;
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (g_log.size() !== 12) $display("FAIL rr_grant_count: got %0d expected 12", g_log.size());
      else begin
         n_pass++;
         for (int k = 0; k < 12; k++) begin
            n_checks++; if (g_log[k] !== k % 4) $display("FAIL rr_grant_%0d: got %0d expected %0d", k, g_log[k], k % 4); else n_pass++;
         end
      end
      n_checks++;
      if (rq_id.size() !== 12) $display("FAIL rr_rsp_count: got %0d expected 12", rq_id.size());
      else begin
         n_pass++;
         for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (rq_id[k] !== k % 4 || rq_data[k] !== exp_h[k % 4])
               $display("FAIL rr_rsp_%0d: got id %0d data %0d expected id %0d data %0d", k, rq_id[k], rq_data[k], k % 4, exp_h[k % 4]);
            else n_pass++;
         end
         n_checks++; if (rq_cyc[11] !== rq_cyc[0] + 11) $display("FAIL rr_rsp_stream: got span %0d expected 11", rq_cyc[11] - rq_cyc[0]); else n_pass++;
      end
   endtask

   task automatic test_random();
      int exp_id[$];
      int exp_a[$];
      int planned = 0;
      int recv    = 0;
      int nfail   = 0;
      int cur [4];
      logic [NREQ-1:0] gnt;
      log_en = 1'b0;
      req_valid = '0;
      fork
         begin
            for (int c = 0; c < 30000 && (planned < NRND || req_valid != '0); c++) begin
               @(negedge clk) gnt = req_ready;
               @(posedge clk); #1;
               for (int i = 0; i < NREQ; i++) begin
                  if (req_valid[i] && gnt[i]) begin
                     exp_id.push_back(i); exp_a.push_back(cur[i]); req_valid[i] = 1'b0;
                  end
               end
               for (int i = 0; i < NREQ; i++) begin
                  if (!req_valid[i] && planned < NRND && $urandom_range(0, 9) < 7) begin
                     cur[i] = int'($urandom_range(0, 4095));
                     set_data(i, cur[i]); req_valid[i] = 1'b1; planned++;
                  end
               end
            end
         end
         begin
            for (int c = 0; c < 40000 && recv < NRND; c++) begin
               @(negedge clk);
               if (rsp_valid) begin
                  n_checks++;
                  if (exp_id.size() == 0) begin
                     nfail++; if (nfail <= 10) $display("FAIL rnd_unexpected: got id %0d data %0d expected no response", rsp_id, rsp_data);
                  end else begin
                     int eid, ea;
                     eid = exp_id.pop_front(); ea = exp_a.pop_front();
                     if (int'(rsp_id) !== eid || int'(rsp_data) !== half_ref(ea)) begin
                        nfail++;
                        if (nfail <= 10) $display("FAIL rnd_rsp_%0d: got id %0d data %0d expected id %0d data %0d (a=%0d)", recv, rsp_id, rsp_data, eid, half_ref(ea), ea);
                     end else n_pass++;
                  end
                  recv++;
               end
            end
         end
      join
      n_checks++; if (recv !== NRND) $display("FAIL rnd_total: got %0d responses expected %0d", recv, NRND); else n_pass++;
      n_checks++; if (exp_id.size() !== 0) $display("FAIL rnd_leftover: got %0d pending expected 0", exp_id.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_err();
      test_reset_mid();
      test_all_valid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
